// File: rtl/lsu_queue.sv
// In-order load/store buffer: CDB operand snoop, head-only address/RAM access, CDB request for load results.
// Optional define LSU_ALIGN_CHECK_EN: flag and suppress word-misaligned accesses via sticky `misalign`.
module lsu_queue #(
    parameter int unsigned DEPTH      = 4,
    parameter logic [3:0]  LABEL_BASE = 4'd12,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned AW         = 8
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        WEN,
    input  logic        opIn,
    input  logic [31:0] dataIn1,
    input  logic [3:0]  label1,
    input  logic [31:0] dataIn2,
    input  logic [3:0]  label2,
    input  logic [15:0] immd16,
    input  logic        BCEN,
    input  logic [3:0]  BClabel,
    input  logic [31:0] BCdata,
    input  logic        requireAC,
    output logic        isFull,
    output logic [3:0]  labelOut,
    output logic        require,
    output logic [31:0] result,
    output logic [3:0]  resultLabel,
    output logic        misalign
);

    localparam int unsigned PW        = $clog2(DEPTH);
    localparam int unsigned CNT_W     = PW + 1;
    localparam int unsigned CW        = $clog2(MEM_LAT + 1);
    localparam int unsigned RAM_WORDS = 1 << AW;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_MEM, S_CDB} state_t;

    logic [DEPTH-1:0] e_valid;
    logic             e_op  [DEPTH];
    logic [31:0]      e_vj  [DEPTH];
    logic [3:0]       e_qj  [DEPTH];
    logic [31:0]      e_vk  [DEPTH];
    logic [3:0]       e_qk  [DEPTH];
    logic [15:0]      e_imm [DEPTH];

    logic [PW-1:0]    head, tail, head_d, tail_d;
    logic [CNT_W-1:0] count, count_d;
    state_t           state, state_d;
    logic [CW-1:0]    cnt;
    logic [AW-1:0]    widx;
    logic             mis_q;
    logic [31:0]      ram [RAM_WORDS];

    logic        iss, head_ready, mem_last, retire, st_wr, addr_mis;
    logic        bypass_j, bypass_k;
    logic [31:0] addr;
    logic        require_d;
    logic [31:0] result_d;
    logic [3:0]  rlabel_d;

    // A tag counts as resolved if it is zero or is being broadcast this cycle.
    function automatic logic tag_ready(input logic [3:0] q, input logic en, input logic [3:0] tag);
        return (q == 4'd0) || (en && (tag == q));
    endfunction

    assign iss      = WEN && !isFull;
    assign bypass_j = (label1 != 4'd0) && BCEN && (BClabel == label1);
    assign bypass_k = (label2 != 4'd0) && BCEN && (BClabel == label2);
    assign addr     = e_vj[head] + {{16{e_imm[head][15]}}, e_imm[head]};
    assign mem_last = (state == S_MEM) && (cnt == '0);
    assign st_wr    = mem_last && e_op[head] && !mis_q;
    assign retire   = (mem_last && e_op[head]) || ((state == S_CDB) && requireAC);

`ifdef LSU_ALIGN_CHECK_EN
    assign addr_mis = (addr[1:0] != 2'd0);
    logic unused_addr;
    assign unused_addr = ^addr[31:AW+2];
`else
    assign addr_mis = 1'b0;
    logic unused_addr;
    assign unused_addr = ^{addr[31:AW+2], addr[1:0]};
`endif

    // An empty queue lets the op being issued start straight away.
    always_comb begin
        head_ready = 1'b0;
        if (count == '0)
            head_ready = iss && tag_ready(label1, BCEN, BClabel)
                         && (!opIn || tag_ready(label2, BCEN, BClabel));
        else
            head_ready = e_valid[head] && tag_ready(e_qj[head], BCEN, BClabel)
                         && (!e_op[head] || tag_ready(e_qk[head], BCEN, BClabel));
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (head_ready) state_d = S_ADDR;
            S_ADDR:  state_d = S_MEM;
            S_MEM:   if (cnt == '0) state_d = e_op[head] ? S_IDLE : S_CDB;
            S_CDB:   if (requireAC) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        require_d = (state_d == S_CDB);
        result_d  = result;
        rlabel_d  = resultLabel;
        if (mem_last && !e_op[head]) begin
            result_d = mis_q ? 32'd0 : ram[widx];
            rlabel_d = LABEL_BASE + 4'(head);
        end
    end

    always_comb begin
        head_d  = head + PW'(retire);
        tail_d  = tail + PW'(iss);
        count_d = count + CNT_W'(iss) - CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            isFull      <= 1'b0;
            labelOut    <= LABEL_BASE;
            require     <= 1'b0;
            result      <= '0;
            resultLabel <= '0;
        end else begin
            head        <= head_d;
            tail        <= tail_d;
            count       <= count_d;
            isFull      <= (count_d == CNT_W'(DEPTH));
            labelOut    <= LABEL_BASE + 4'(tail_d);
            require     <= require_d;
            result      <= result_d;
            resultLabel <= rlabel_d;
        end
    end

    // Address stage and MEM down-counter.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt   <= '0;
            widx  <= '0;
            mis_q <= 1'b0;
        end else if (state == S_ADDR) begin
            cnt   <= CW'(MEM_LAT - 1);
            widx  <= addr[AW+1:2];
            mis_q <= addr_mis;
        end else if (state == S_MEM && cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

`ifdef LSU_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)                          misalign <= 1'b0;
        else if (state == S_ADDR && addr_mis) misalign <= 1'b1;
    end
`else
    assign misalign = 1'b0;
`endif

    // Entry storage: snoop first, then issue write, then retire clear.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            e_valid <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                e_op[PW'(i)]  <= 1'b0;
                e_vj[PW'(i)]  <= '0;
                e_qj[PW'(i)]  <= '0;
                e_vk[PW'(i)]  <= '0;
                e_qk[PW'(i)]  <= '0;
                e_imm[PW'(i)] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (e_valid[PW'(i)] && e_qj[PW'(i)] != 4'd0 && BCEN && BClabel == e_qj[PW'(i)]) begin
                    e_vj[PW'(i)] <= BCdata;
                    e_qj[PW'(i)] <= 4'd0;
                end
                if (e_valid[PW'(i)] && e_qk[PW'(i)] != 4'd0 && BCEN && BClabel == e_qk[PW'(i)]) begin
                    e_vk[PW'(i)] <= BCdata;
                    e_qk[PW'(i)] <= 4'd0;
                end
            end
            if (iss) begin
                e_valid[tail] <= 1'b1;
                e_op[tail]    <= opIn;
                e_vj[tail]    <= bypass_j ? BCdata : dataIn1;
                e_qj[tail]    <= bypass_j ? 4'd0 : label1;
                e_vk[tail]    <= bypass_k ? BCdata : dataIn2;
                e_qk[tail]    <= (bypass_k || !opIn) ? 4'd0 : label2;
                e_imm[tail]   <= immd16;
            end
            if (retire) e_valid[head] <= 1'b0;
        end
    end

    // Data RAM is deliberately not reset.
    always_ff @(posedge clk) begin
        if (st_wr) ram[widx] <= e_vk[head];
    end

endmodule
